// File: rtl/fifo_pkg.sv
// Shared constants and types for the async FIFO read-side packer.
//   DATA_WIDTH : width of one FIFO word
//   ADDR_WIDTH : FIFO address width (shared with the FIFO core)
//   PACK       : FIFO words per output beat (>= 2)
//   CNT_W      : lane counter width, holds 0..PACK
//   beat_t     : one output beat {data, keep, last}
package fifo_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int PACK       = 4;

  // Counter must represent the value PACK itself (full accumulator), hence PACK+1.
  function automatic int cnt_w(input int pack);
    return $clog2(pack + 1);
  endfunction

  localparam int CNT_W = cnt_w(PACK);

  typedef struct packed {
    logic [PACK-1:0][DATA_WIDTH-1:0] data;
    logic [PACK-1:0]                 keep;
    logic                            last;
  } beat_t;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Bus bundle for fifo_rd_packer: FIFO read side plus the packed output stream.
//   rempty/rdata/rinc : FIFO read port (rdata valid one cycle after an accepted pop)
//   flush             : one-cycle request to emit a partially filled beat
//   m_valid/m_ready   : output stream handshake
//   m_data/m_keep/m_last : packed beat, lane mask, flush-produced marker
// Handshake: a beat transfers on every rising clock edge where m_valid && m_ready.
// Once m_valid is high, m_data/m_keep/m_last stay stable until that transfer;
// m_ready may change freely and never depends combinationally on m_valid.
interface fifo_rd_packer_if;
  import fifo_pkg::*;

  logic                       rempty;
  logic [DATA_WIDTH-1:0]      rdata;
  logic                       rinc;
  logic                       flush;
  logic                       m_valid;
  logic                       m_ready;
  logic [DATA_WIDTH*PACK-1:0] m_data;
  logic [PACK-1:0]            m_keep;
  logic                       m_last;

  // master: the packer itself
  modport master (
    input  rempty, rdata, flush, m_ready,
    output rinc, m_valid, m_data, m_keep, m_last
  );

  // slave: FIFO + downstream consumer environment
  modport slave (
    output rempty, rdata, flush, m_ready,
    input  rinc, m_valid, m_data, m_keep, m_last
  );

endinterface

// File: rtl/fifo_pack_out_reg.sv
// Single-entry valid/ready holding register for one beat_t.
//   clk_i/rst_i  : clock, asynchronous active-high reset
//   in_valid_i   : upstream offers a beat
//   in_beat_i    : offered beat
//   in_ready_o   : register can take a beat this cycle (empty, or draining now)
//   out_valid_o  : registered beat valid
//   out_beat_o   : registered beat, held stable while stalled
//   out_ready_i  : downstream accepts the beat
module fifo_pack_out_reg
  import fifo_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  in_valid_i,
  input  beat_t in_beat_i,
  output logic  in_ready_o,
  output logic  out_valid_o,
  output beat_t out_beat_o,
  input  logic  out_ready_i
);

  logic  valid_q;
  beat_t beat_q;

  // Accept a new beat when empty or when the held beat leaves this cycle.
  assign in_ready_o = !valid_q || out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      beat_q  <= in_beat_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_beat_o  = beat_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side consumer of the async FIFO (rclk domain). Pops words, packs PACK
// consecutive words into one beat (first word in lane 0) and offers it on a
// valid/ready stream. A flush emits the partially filled accumulator with a
// lane-keep mask and m_last=1.
//   rclk/rrst        : read clock, asynchronous active-high reset
//   bus (master)     : FIFO read port + output stream (see fifo_rd_packer_if)
//   dbg_cnt_o        : landed words in the accumulator
//   dbg_pend_o       : a popped word is in flight (lands next cycle)
//   dbg_flush_pend_o : flush requested, not yet completed
module fifo_rd_packer
  import fifo_pkg::*;
(
  input  logic             rclk,
  input  logic             rrst,
  fifo_rd_packer_if.master bus,
  output logic [CNT_W-1:0] dbg_cnt_o,
  output logic             dbg_pend_o,
  output logic             dbg_flush_pend_o
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PACK);

  logic [PACK-1:0][DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            pend_q, pend_d;
  logic                            flush_pend_q, flush_pend_d;

  logic [CNT_W-1:0] fill;
  logic             out_free;
  logic             full_xfer;
  logic             flush_go;
  logic             flush_beat;
  logic             beat_valid;
  beat_t            beat_in;
  beat_t            beat_out;
  logic             out_valid;

  // Lanes already landed plus the word in flight; never exceeds PACK.
  assign fill = cnt_q + CNT_W'(pend_q);

  // Pop only when the word has a lane reserved for it.
  assign bus.rinc = !rrst && !bus.rempty && !flush_pend_q && (fill < CNT_FULL);

  assign full_xfer  = (cnt_q == CNT_FULL) && out_free;
  // Flush completes once the in-flight word has landed and the output is free.
  // With a full accumulator the normal transfer serves the flush (no extra beat).
  assign flush_go   = flush_pend_q && !pend_q && out_free;
  assign flush_beat = flush_go && (cnt_q != '0) && (cnt_q != CNT_FULL);
  assign beat_valid = full_xfer || flush_beat;

  // Only landed lanes are kept; others are forced to zero.
  always_comb begin
    beat_in = '0;
    for (int k = 0; k < PACK; k++) begin
      if (CNT_W'(k) < cnt_q) begin
        beat_in.keep[k] = 1'b1;
        beat_in.data[k] = acc_q[k];
      end
    end
    beat_in.last = (cnt_q != CNT_FULL);
  end

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    pend_d       = bus.rinc;
    flush_pend_d = flush_pend_q;
    if (pend_q) begin
      for (int k = 0; k < PACK; k++) begin
        if (cnt_q == CNT_W'(k)) acc_d[k] = bus.rdata;
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Landing and beat emission never coincide: emission needs pend_q low
    // (flush) or a full accumulator, which blocks pops.
    if (beat_valid) cnt_d = '0;
    if (flush_go) flush_pend_d = 1'b0;
    if (bus.flush) flush_pend_d = 1'b1;
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  fifo_pack_out_reg u_out_reg (
    .clk_i       (rclk),
    .rst_i       (rrst),
    .in_valid_i  (beat_valid),
    .in_beat_i   (beat_in),
    .in_ready_o  (out_free),
    .out_valid_o (out_valid),
    .out_beat_o  (beat_out),
    .out_ready_i (bus.m_ready)
  );

  assign bus.m_valid = out_valid;
  assign bus.m_data  = beat_out.data;
  assign bus.m_keep  = beat_out.keep;
  assign bus.m_last  = beat_out.last;

  assign dbg_cnt_o        = cnt_q;
  assign dbg_pend_o       = pend_q;
  assign dbg_flush_pend_o = flush_pend_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
module tb_fifo_rd_packer;
  import fifo_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int BW = DW * PACK;
  localparam int EW = BW + PACK + 1;

  // ---------------- clock / reset ----------------
  logic rclk = 1'b0;
  logic rrst = 1'b1;
  always #5 rclk = ~rclk;

  fifo_rd_packer_if bus ();
  logic [CNT_W-1:0] dbg_cnt;
  logic             dbg_pend;
  logic             dbg_flush_pend;

  fifo_rd_packer dut (
    .rclk             (rclk),
    .rrst             (rrst),
    .bus              (bus),
    .dbg_cnt_o        (dbg_cnt),
    .dbg_pend_o       (dbg_pend),
    .dbg_flush_pend_o (dbg_flush_pend)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] fifo_q[$];   // words waiting in the modelled FIFO
  logic [DW-1:0] part_q[$];   // pushed words not yet part of an expected beat
  logic [EW-1:0] exp_q[$];    // expected beats {data, keep, last} in order
  logic          empty_force = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_beats  = 0;

  logic          stall_prev = 1'b0;
  logic [EW:0]   hold_prev  = '0;

  function automatic logic [EW-1:0] make_beat(input logic last);
    logic [BW-1:0]   d;
    logic [PACK-1:0] k;
    d = '0;
    k = '0;
    for (int i = 0; i < part_q.size(); i++) begin
      d[i*DW +: DW] = part_q[i];
      k[i] = 1'b1;
    end
    return {d, k, last};
  endfunction

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    part_q.push_back(w);
    if (part_q.size() == PACK) begin
      exp_q.push_back(make_beat(1'b0));
      part_q.delete();
    end
  endtask

  task automatic model_flush();
    if (part_q.size() > 0) begin
      exp_q.push_back(make_beat(1'b1));
      part_q.delete();
    end
  endtask

  // One clock cycle: FIFO flag update and output sampling at negedge+1,
  // FIFO pop at posedge, return at posedge+1 for the next stimulus.
  task automatic tick();
    logic          pop_now;
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    @(negedge rclk);
    bus.rempty = (fifo_q.size() == 0) || empty_force;
    #1;
    pop_now = bus.rinc;
    if (pop_now) begin
      n_checks++;
      if (bus.rempty !== 1'b0) $display("FAIL underflow: rinc=1 with rempty=%b", bus.rempty);
      else n_pass++;
    end
    if (!rrst) begin
      if (stall_prev) begin
        n_checks++;
        if ({bus.m_valid, bus.m_data, bus.m_keep, bus.m_last} !== hold_prev)
          $display("FAIL hold: got %h, required %h",
                   {bus.m_valid, bus.m_data, bus.m_keep, bus.m_last}, hold_prev);
        else n_pass++;
      end
      if (bus.m_valid && bus.m_ready) begin
        got = {bus.m_data, bus.m_keep, bus.m_last};
        n_beats++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL beat: unexpected beat %h, required none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) $display("FAIL beat: got %h, required %h", got, e);
          else n_pass++;
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      hold_prev  = {bus.m_valid, bus.m_data, bus.m_keep, bus.m_last};
    end else begin
      stall_prev = 1'b0;
    end
    @(posedge rclk);
    if (pop_now && fifo_q.size() > 0) bus.rdata <= fifo_q.pop_front();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_popped(input string name);
    int t;
    t = 0;
    while (fifo_q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    ticks(3);
    n_checks++;
    if (fifo_q.size() != 0) $display("FAIL %s_pop_timeout: %0d words left, required 0", name, fifo_q.size());
    else n_pass++;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && t < 300) begin
      tick();
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL %s_drain_timeout: %0d beats outstanding, required 0", name, exp_q.size());
    else n_pass++;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ticks(2);
    n_checks++;
    if ({bus.m_valid, bus.m_data, bus.m_keep, bus.m_last, bus.rinc} !== '0)
      $display("FAIL reset_outputs: got %h, required 0",
               {bus.m_valid, bus.m_data, bus.m_keep, bus.m_last, bus.rinc});
    else n_pass++;
    rrst = 1'b0;
    ticks(2);
  endtask

  task automatic test_reset_midstream();
    int t;
    bus.m_ready = 1'b1;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    t = 0;
    while (!(dbg_cnt == CNT_W'(2) && dbg_pend) && t < 20) begin
      tick();
      t++;
    end
    n_checks++;
    if (!(dbg_cnt == CNT_W'(2) && dbg_pend)) $display("FAIL midreset_setup: cnt=%0d pend=%b, required 2/1", dbg_cnt, dbg_pend);
    else n_pass++;
    rrst = 1'b1;
    fifo_q.delete();
    part_q.delete();
    exp_q.delete();
    #1;
    n_checks++;
    if ({bus.m_valid, bus.m_data, bus.m_keep, bus.m_last, dbg_cnt, dbg_pend} !== '0)
      $display("FAIL midreset_state: got %h, required 0",
               {bus.m_valid, bus.m_data, bus.m_keep, bus.m_last, dbg_cnt, dbg_pend});
    else n_pass++;
    push_word(8'h99);
    tick();
    n_checks++;
    if (bus.rinc !== 1'b0) $display("FAIL midreset_rinc: got %b with rempty=%b, required 0", bus.rinc, bus.rempty);
    else n_pass++;
    rrst = 1'b0;
    push_word(8'h55);
    push_word(8'h66);
    push_word(8'h77);
    wait_drain("midreset");
  endtask

  task automatic test_stream();
    int n0;
    n0 = n_beats;
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    wait_drain("stream");
    n_checks++;
    if (n_beats - n0 != 2) $display("FAIL stream_beats: got %0d, required 2", n_beats - n0);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w[12];
    bus.m_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      w[i] = DW'($urandom_range(0, 255));
      push_word(w[i]);
    end
    ticks(14);
    n_checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== {w[3], w[2], w[1], w[0]})
      $display("FAIL bp_held: valid=%b data=%h, required 1/%h", bus.m_valid, bus.m_data, {w[3], w[2], w[1], w[0]});
    else n_pass++;
    n_checks++;
    if (fifo_q.size() != 4 || dbg_cnt !== CNT_W'(4))
      $display("FAIL bp_popped: left=%0d cnt=%0d, required 4/4", fifo_q.size(), dbg_cnt);
    else n_pass++;
    bus.m_ready = 1'b1;
    wait_drain("bp");
  endtask

  task automatic test_flush_partial();
    int t;
    bus.m_ready = 1'b1;
    push_word(8'hA1);
    push_word(8'hA2);
    push_word(8'hA3);
    wait_popped("flush_partial");
    model_flush();
    pulse_flush();
    t = 0;
    while (!bus.m_valid && t < 10) begin
      tick();
      t++;
    end
    n_checks++;
    if ({bus.m_valid, bus.m_data, bus.m_keep, bus.m_last} !== {1'b1, 32'h00A3A2A1, 4'b0111, 1'b1})
      $display("FAIL flush_partial_beat: got %b/%h/%b/%b, required 1/00a3a2a1/0111/1",
               bus.m_valid, bus.m_data, bus.m_keep, bus.m_last);
    else n_pass++;
    for (int i = 0; i < 4; i++) push_word(8'hB0 + 8'(i));
    wait_drain("flush_partial");
  endtask

  task automatic test_flush_empty_pending();
    int n0;
    bus.m_ready = 1'b1;
    n0 = n_beats;
    pulse_flush();
    ticks(6);
    n_checks++;
    if (n_beats != n0) $display("FAIL flush_empty: got %0d beats, required 0", n_beats - n0);
    else n_pass++;
    // Word popped in the same cycle as the flush pulse is still in flight.
    push_word(8'hC7);
    model_flush();
    pulse_flush();
    wait_drain("flush_pend");
    n_checks++;
    if (n_beats - n0 != 1) $display("FAIL flush_pend_beats: got %0d, required 1", n_beats - n0);
    else n_pass++;
    n0 = n_beats;
    push_word(8'hD1);
    push_word(8'hD2);
    wait_popped("double_flush");
    model_flush();
    bus.flush = 1'b1;
    ticks(2);
    bus.flush = 1'b0;
    wait_drain("double_flush");
    ticks(5);
    n_checks++;
    if (n_beats - n0 != 1) $display("FAIL double_flush_beats: got %0d, required 1", n_beats - n0);
    else n_pass++;
  endtask

  task automatic test_flush_full();
    int n0;
    n0 = n_beats;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(DW'($urandom_range(0, 255)));
    ticks(14);
    model_flush();
    pulse_flush();
    bus.m_ready = 1'b1;
    wait_drain("flush_full");
    ticks(5);
    n_checks++;
    if (n_beats - n0 != 2) $display("FAIL flush_full_beats: got %0d, required 2", n_beats - n0);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      bus.m_ready = ($urandom_range(0, 2) != 0);
      empty_force = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0 && fifo_q.size() < 16) push_word(DW'($urandom_range(0, 255)));
      tick();
    end
    bus.m_ready = 1'b1;
    empty_force = 1'b0;
    wait_popped("random");
    model_flush();
    pulse_flush();
    wait_drain("random");
  endtask

  initial begin
    bus.flush   = 1'b0;
    bus.m_ready = 1'b0;
    bus.rdata  <= '0;
    test_reset();
    test_reset_midstream();
    test_stream();
    test_backpressure();
    test_flush_partial();
    test_flush_empty_pending();
    test_flush_full();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
